axi_slave_mem: RTL and testbench

- AXI responder (slave) backed by an internal register-array memory. It is the other end of the initiator/monitor traffic on axi_if, and serves as the DUT-side target in the AXI verification benches.
- Write path (AW/W/B) and read path (AR/R) are independent FSMs and may run concurrently.
- The bus has no WLAST/RLAST; the slave counts beats from AxLEN.

---
 rtl/axi_slave_mem_pkg.sv | 22 ++
 rtl/axi_burst_addr.sv | 40 ++++
 rtl/axi_slave_mem.sv | 274 +++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_mem_pkg.sv
// Shared constants and FSM state types for the AXI slave memory.
package axi_slave_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Per-beat address helper: next beat address, memory word index and beat error.
module axi_burst_addr
    import axi_slave_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 8
) (
    input  logic [31:0]       i_addr,
    input  logic [2:0]        i_size,
    input  logic [1:0]        i_burst,
    output logic [31:0]       o_next_addr,
    output logic [MEM_AW-1:0] o_word_idx,
    output logic              o_beat_err
);
    localparam int         LNB      = $clog2(DATA_W / 8);
    localparam int         TOP      = MEM_AW + LNB;
    localparam logic [2:0] MAX_SIZE = 3'(LNB);

    logic w_burst_err;
    logic w_size_err;
    logic w_range_err;

    // Advance the address by burst type; WRAP and reserved bursts are flagged as errors.
    always_comb begin
        w_burst_err = 1'b0;
        o_next_addr = i_addr;
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_INCR:  o_next_addr = i_addr + (32'd1 << i_size);
            BURST_WRAP:  w_burst_err = 1'b1;
            default:     w_burst_err = 1'b1;
        endcase
    end

    assign w_size_err  = (i_size > MAX_SIZE);
    assign w_range_err = |i_addr[31:TOP];
    assign o_word_idx  = i_addr[TOP-1:LNB];
    assign o_beat_err  = w_burst_err | w_size_err | w_range_err;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI responder backed by a register-array memory; independent write and read FSMs.
module axi_slave_mem
    import axi_slave_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 8
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [31:0]       AWADDR,
    input  logic [7:0]        AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [31:0]       ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY
);
    localparam int DEPTH = 2 ** MEM_AW;

    // Storage has no reset: contents are undefined after reset.
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write path state
    wr_state_e   r_wstate, w_wstate_nxt;
    logic [31:0] r_waddr, w_waddr_nxt;
    logic [7:0]  r_wcnt, w_wcnt_nxt;
    logic [2:0]  r_wsize, w_wsize_nxt;
    logic [1:0]  r_wburst, w_wburst_nxt;
    logic        r_werr, w_werr_nxt;
    logic        r_awready, w_awready_nxt;
    logic        r_wready, w_wready_nxt;
    logic        r_bvalid, w_bvalid_nxt;
    logic [1:0]  r_bresp, w_bresp_nxt;
    logic        w_mem_we;
    logic [31:0]       w_wnext_addr;
    logic [MEM_AW-1:0] w_widx;
    logic              w_wbeat_err;

    // Read path state; r_raddr always points at the next beat to be loaded
    rd_state_e   r_rstate, w_rstate_nxt;
    logic [31:0] r_raddr, w_raddr_nxt;
    logic [7:0]  r_rcnt, w_rcnt_nxt;
    logic [2:0]  r_rsize, w_rsize_nxt;
    logic [1:0]  r_rburst, w_rburst_nxt;
    logic        r_arready, w_arready_nxt;
    logic        r_rvalid, w_rvalid_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic [1:0]  r_rresp, w_rresp_nxt;
    logic [31:0]       w_rsel_addr;
    logic [2:0]        w_rsel_size;
    logic [1:0]        w_rsel_burst;
    logic [31:0]       w_rnext_addr;
    logic [MEM_AW-1:0] w_ridx;
    logic              w_rbeat_err;
    logic [DATA_W-1:0] w_rbeat_data;
    logic [1:0]        w_rbeat_resp;

    axi_burst_addr #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) u_waddr (
        .i_addr      (r_waddr),
        .i_size      (r_wsize),
        .i_burst     (r_wburst),
        .o_next_addr (w_wnext_addr),
        .o_word_idx  (w_widx),
        .o_beat_err  (w_wbeat_err)
    );

    // In idle the first beat is computed straight from the AR channel so it can load on the handshake.
    assign w_rsel_addr  = (r_rstate == R_IDLE) ? ARADDR  : r_raddr;
    assign w_rsel_size  = (r_rstate == R_IDLE) ? ARSIZE  : r_rsize;
    assign w_rsel_burst = (r_rstate == R_IDLE) ? ARBURST : r_rburst;

    axi_burst_addr #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) u_raddr (
        .i_addr      (w_rsel_addr),
        .i_size      (w_rsel_size),
        .i_burst     (w_rsel_burst),
        .o_next_addr (w_rnext_addr),
        .o_word_idx  (w_ridx),
        .o_beat_err  (w_rbeat_err)
    );

    assign w_rbeat_data = w_rbeat_err ? {DATA_W{1'b0}} : r_mem[w_ridx];
    assign w_rbeat_resp = w_rbeat_err ? RESP_SLVERR : RESP_OKAY;

    // Write FSM next-state and next registered outputs.
    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_waddr_nxt   = r_waddr;
        w_wcnt_nxt    = r_wcnt;
        w_wsize_nxt   = r_wsize;
        w_wburst_nxt  = r_wburst;
        w_werr_nxt    = r_werr;
        w_awready_nxt = 1'b0;
        w_wready_nxt  = 1'b0;
        w_bvalid_nxt  = 1'b0;
        w_bresp_nxt   = r_bresp;
        w_mem_we      = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (AWVALID && r_awready) begin
                    w_waddr_nxt   = AWADDR;
                    w_wcnt_nxt    = AWLEN;
                    w_wsize_nxt   = AWSIZE;
                    w_wburst_nxt  = AWBURST;
                    w_werr_nxt    = 1'b0;
                    w_wstate_nxt  = W_DATA;
                    w_wready_nxt  = 1'b1;
                end else begin
                    w_awready_nxt = 1'b1;
                end
            end
            W_DATA: begin
                if (WVALID && r_wready) begin
                    w_mem_we    = ~w_wbeat_err;
                    w_werr_nxt  = r_werr | w_wbeat_err;
                    w_waddr_nxt = w_wnext_addr;
                    if (r_wcnt == 8'd0) begin
                        w_wstate_nxt = W_RESP;
                        w_bvalid_nxt = 1'b1;
                        w_bresp_nxt  = (r_werr | w_wbeat_err) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_wcnt_nxt   = r_wcnt - 8'd1;
                        w_wready_nxt = 1'b1;
                    end
                end else begin
                    w_wready_nxt = 1'b1;
                end
            end
            W_RESP: begin
                if (BREADY && r_bvalid) begin
                    w_wstate_nxt  = W_IDLE;
                    w_bresp_nxt   = RESP_OKAY;
                    w_awready_nxt = 1'b1;
                end else begin
                    w_bvalid_nxt = 1'b1;
                end
            end
            default: begin
                w_wstate_nxt = W_IDLE;
            end
        endcase
    end

    // Write FSM state and registered outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate  <= W_IDLE;
            r_waddr   <= 32'd0;
            r_wcnt    <= 8'd0;
            r_wsize   <= 3'd0;
            r_wburst  <= 2'd0;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'd0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_wsize   <= w_wsize_nxt;
            r_wburst  <= w_wburst_nxt;
            r_werr    <= w_werr_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
        end
    end

    // Memory write port; a read in the same edge still sees the old word.
    always_ff @(posedge ACLK) begin
        if (w_mem_we) begin
            r_mem[w_widx] <= WDATA;
        end
    end

    // Read FSM next-state; each handshake loads the following beat in the same edge.
    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_raddr_nxt   = r_raddr;
        w_rcnt_nxt    = r_rcnt;
        w_rsize_nxt   = r_rsize;
        w_rburst_nxt  = r_rburst;
        w_arready_nxt = 1'b0;
        w_rvalid_nxt  = r_rvalid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        case (r_rstate)
            R_IDLE: begin
                if (ARVALID && r_arready) begin
                    w_rsize_nxt  = ARSIZE;
                    w_rburst_nxt = ARBURST;
                    w_rcnt_nxt   = ARLEN;
                    w_raddr_nxt  = w_rnext_addr;
                    w_rdata_nxt  = w_rbeat_data;
                    w_rresp_nxt  = w_rbeat_resp;
                    w_rvalid_nxt = 1'b1;
                    w_rstate_nxt = R_DATA;
                end else begin
                    w_arready_nxt = 1'b1;
                end
            end
            R_DATA: begin
                if (r_rvalid && RREADY) begin
                    if (r_rcnt == 8'd0) begin
                        w_rvalid_nxt  = 1'b0;
                        w_rstate_nxt  = R_IDLE;
                        w_arready_nxt = 1'b1;
                    end else begin
                        w_rdata_nxt = w_rbeat_data;
                        w_rresp_nxt = w_rbeat_resp;
                        w_raddr_nxt = w_rnext_addr;
                        w_rcnt_nxt  = r_rcnt - 8'd1;
                    end
                end else begin
                    w_rvalid_nxt = r_rvalid;
                end
            end
            default: begin
                w_rstate_nxt = R_IDLE;
            end
        endcase
    end

    // Read FSM state and registered outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate  <= R_IDLE;
            r_raddr   <= 32'd0;
            r_rcnt    <= 8'd0;
            r_rsize   <= 3'd0;
            r_rburst  <= 2'd0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= {DATA_W{1'b0}};
            r_rresp   <= 2'd0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_raddr   <= w_raddr_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_rsize   <= w_rsize_nxt;
            r_rburst  <= w_rburst_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench: behavioural word-memory model, per-cycle R/B monitor, directed + random traffic.
module tb_axi_slave_mem;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] AWADDR;  logic [7:0] AWLEN; logic [2:0] AWSIZE; logic [1:0] AWBURST;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;   logic WVALID, WREADY;
    logic [1:0]  BRESP;   logic BVALID, BREADY;
    logic [31:0] ARADDR;  logic [7:0] ARLEN; logic [2:0] ARSIZE; logic [1:0] ARBURST;
    logic        ARVALID, ARREADY;
    logic [31:0] RDATA;   logic [1:0] RRESP; logic RVALID, RREADY;

    axi_slave_mem #(.DATA_W(32), .MEM_AW(8)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    typedef struct { logic [31:0] d; logic [1:0] resp; bit chk; } exp_beat_t;
    typedef struct { logic [31:0] d; logic [1:0] resp; int c; } got_beat_t;

    exp_beat_t   exp_r[$];
    logic [1:0]  exp_b[$];
    got_beat_t   got_r[$];
    logic [31:0] mdl_mem [256];
    bit          mdl_ok  [256];
    bit          in_rst = 1'b1;
    bit          rd_busy = 1'b0;
    logic [1:0]  last_bresp = 2'b11;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // A beat is in error for WRAP/reserved bursts, SIZE beyond 4 bytes, or a word index past 255.
    function automatic bit mdl_err(input logic [31:0] a, input logic [2:0] s, input logic [1:0] b);
        return (b >= 2'd2) || (s > 3'd2) || (a >= 32'h400);
    endfunction

    function automatic logic [31:0] mdl_next(input logic [31:0] a, input logic [2:0] s, input logic [1:0] b);
        return (b == 2'd0) ? a : a + (32'd1 << s);
    endfunction

    // Per-cycle compare of R and B channels against the model's expected queues.
    always @(negedge ACLK) begin
        if (ARESETN && !in_rst) begin
            chk("r_spurious", (RVALID && exp_r.size() == 0), 64'd0);
            chk("b_spurious", (BVALID && exp_b.size() == 0), 64'd0);
            chk("aw_while_busy", (BVALID && AWREADY), 64'd0);
            if (RVALID && exp_r.size() != 0) begin
                chk("rresp", RRESP, exp_r[0].resp);
                if (exp_r[0].chk) chk("rdata", RDATA, exp_r[0].d);
                if (RREADY) begin
                    got_r.push_back('{RDATA, RRESP, cyc});
                    void'(exp_r.pop_front());
                end
            end else if (rd_busy && exp_r.size() != 0) begin
                chk("rvalid_held", RVALID, 64'd1);
            end
            if (BVALID && exp_b.size() != 0) begin
                chk("bresp", BRESP, exp_b[0]);
                if (BREADY) begin
                    last_bresp = BRESP;
                    void'(exp_b.pop_front());
                end
            end
        end
    end

    task automatic chk_got(input string nm, input int i, input logic [31:0] d, input logic [1:0] r);
        if (i < got_r.size()) begin
            chk(nm, got_r[i].d, d);
            chk({nm, "_resp"}, got_r[i].resp, r);
        end else begin
            chk({nm, "_count"}, got_r.size(), i + 1);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bu, input logic [31:0] base, input bit rnd,
                            input bit gaps, input int bdelay, output int lat);
        logic [31:0] d[$];
        logic [31:0] cur;
        bit anyerr;
        int k, hs, n;
        cur = a; anyerr = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] v;
            v = rnd ? $urandom() : base + 32'(i);
            d.push_back(v);
            if (mdl_err(cur, sz, bu)) anyerr = 1'b1;
            else begin mdl_mem[cur[9:2]] = v; mdl_ok[cur[9:2]] = 1'b1; end
            cur = mdl_next(cur, sz, bu);
        end
        exp_b.push_back(anyerr ? 2'b10 : 2'b00);
        @(posedge ACLK); #1;
        AWADDR = a; AWLEN = len; AWSIZE = sz; AWBURST = bu; AWVALID = 1'b1;
        k = 0;
        do begin @(negedge ACLK); k++; end while (!AWREADY && k < 200);
        chk("aw_accept", AWREADY, 64'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; hs = cyc;
        for (int i = 0; i < d.size(); i++) begin
            WDATA = d[i];
            if (gaps) begin
                WVALID = 1'b0;
                n = $urandom_range(0, 2);
                repeat (n) begin @(posedge ACLK); #1; end
            end
            WVALID = 1'b1;
            k = 0;
            do begin @(negedge ACLK); k++; end while (!WREADY && k < 200);
            chk("w_accept", WREADY, 64'd1);
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0;
        k = 0;
        do begin @(negedge ACLK); k++; end while (!BVALID && k < 300);
        chk("b_valid", BVALID, 64'd1);
        lat = cyc - hs + 1;
        repeat (bdelay) begin @(negedge ACLK); chk("b_hold", BVALID, 64'd1); end
        @(posedge ACLK); #1; BREADY = 1'b1;
        @(posedge ACLK); #1; BREADY = 1'b0;
    endtask

    // mode 0: RREADY high; 1: random; 2: one beat, then 3 stall cycles, then high.
    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input int mode, output int hs);
        logic [31:0] cur;
        int k;
        cur = a;
        got_r.delete();
        for (int i = 0; i <= int'(len); i++) begin
            exp_beat_t e;
            bit er;
            er = mdl_err(cur, sz, bu);
            e.resp = er ? 2'b10 : 2'b00;
            e.d    = er ? 32'd0 : mdl_mem[cur[9:2]];
            e.chk  = er || mdl_ok[cur[9:2]];
            exp_r.push_back(e);
            cur = mdl_next(cur, sz, bu);
        end
        @(posedge ACLK); #1;
        ARADDR = a; ARLEN = len; ARSIZE = sz; ARBURST = bu; ARVALID = 1'b1;
        k = 0;
        do begin @(negedge ACLK); k++; end while (!ARREADY && k < 200);
        chk("ar_accept", ARREADY, 64'd1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0; hs = cyc; rd_busy = 1'b1;
        k = 0;
        while (exp_r.size() != 0 && k < 3000) begin
            if (mode == 1)      RREADY = ($urandom_range(0, 3) != 0);
            else if (mode == 2) RREADY = !(k >= 1 && k <= 3);
            else                RREADY = 1'b1;
            @(posedge ACLK); #1; k++;
        end
        rd_busy = 1'b0; RREADY = 1'b0;
        chk("r_done", exp_r.size(), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, hs, lat2, hs2;
        AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
        WDATA = 0; WVALID = 0; BREADY = 0;
        ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARVALID = 0; RREADY = 0;
        for (int i = 0; i < 256; i++) begin mdl_mem[i] = 32'd0; mdl_ok[i] = 1'b0; end
        ARESETN = 1'b1;
        #3 ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("rst_awready", AWREADY, 0); chk("rst_arready", ARREADY, 0);
        chk("rst_wready", WREADY, 0);   chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);   chk("rst_rdata", RDATA, 0);
        ARESETN = 1'b1; in_rst = 1'b0;
        @(negedge ACLK);
        chk("post_rst_awready", AWREADY, 1); chk("post_rst_arready", ARREADY, 1);

        // Single write / read
        do_write(32'h10, 8'd0, 3'd2, 2'b01, 32'hDEADBEEF, 0, 0, 0, lat);
        chk("single_b_latency", lat, 2);
        chk("single_bresp", last_bresp, 2'b00);
        do_read(32'h10, 8'd0, 3'd2, 2'b01, 0, hs);
        chk_got("single_r", 0, 32'hDEADBEEF, 2'b00);
        if (got_r.size() > 0) chk("single_r_first_cycle", got_r[0].c - hs, 0);

        // INCR burst
        do_write(32'h40, 8'd3, 3'd2, 2'b01, 32'd1, 0, 0, 0, lat);
        chk("incr_b_latency", lat, 5);
        do_read(32'h40, 8'd3, 3'd2, 2'b01, 0, hs);
        for (int i = 0; i < 4; i++) chk_got("incr_r", i, 32'(i + 1), 2'b00);
        if (got_r.size() == 4) chk("incr_no_bubble", got_r[3].c - got_r[0].c, 3);
        do_read(32'h44, 8'd0, 3'd2, 2'b01, 0, hs);
        chk_got("incr_r44", 0, 32'd2, 2'b00);

        // FIXED burst
        do_write(32'h20, 8'd2, 3'd2, 2'b00, 32'hA, 0, 0, 0, lat);
        chk("fixed_model_word8", mdl_mem[8], 32'hC);
        do_read(32'h20, 8'd1, 3'd2, 2'b00, 0, hs);
        chk_got("fixed_r0", 0, 32'hC, 2'b00);
        chk_got("fixed_r1", 1, 32'hC, 2'b00);

        // Backpressure on R and B
        do_read(32'h40, 8'd3, 3'd2, 2'b01, 2, hs);
        for (int i = 0; i < 4; i++) chk_got("bp_r", i, 32'(i + 1), 2'b00);
        if (got_r.size() == 4) chk("bp_r_span", got_r[3].c - got_r[0].c, 6);
        do_write(32'h80, 8'd0, 3'd2, 2'b01, 32'h55, 0, 0, 5, lat);
        chk("bp_bresp", last_bresp, 2'b00);

        // Error cases
        do_write(32'h400, 8'd0, 3'd2, 2'b01, 32'h1234, 0, 0, 0, lat);
        chk("err_range_bresp", last_bresp, 2'b10);
        chk("err_range_latency", lat, 2);
        do_write(32'h50, 8'd0, 3'd3, 2'b01, 32'h77, 0, 0, 0, lat);
        chk("err_size_bresp", last_bresp, 2'b10);
        do_read(32'h400, 8'd0, 3'd2, 2'b01, 0, hs);
        chk_got("err_range_r", 0, 32'd0, 2'b10);
        do_read(32'h10, 8'd1, 3'd2, 2'b10, 0, hs);
        chk_got("err_wrap_r0", 0, 32'd0, 2'b10);
        chk_got("err_wrap_r1", 1, 32'd0, 2'b10);
        do_read(32'h10, 8'd0, 3'd2, 2'b01, 0, hs);
        chk_got("err_mem_intact", 0, 32'hDEADBEEF, 2'b00);

        // Concurrent write and read on disjoint regions
        fork
            do_write(32'h100, 8'd5, 3'd2, 2'b01, 32'd0, 1, 1, 2, lat);
            do_read(32'h40, 8'd3, 3'd2, 2'b01, 1, hs);
        join

        // Reset in the middle of a LEN 7 write
        @(posedge ACLK); #1;
        AWADDR = 32'h300; AWLEN = 8'd7; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
        do @(negedge ACLK); while (!AWREADY);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b1;
        for (int i = 0; i < 2; i++) begin
            WDATA = $urandom();
            @(negedge ACLK);
            chk("rst_burst_wready", WREADY, 1);
            @(posedge ACLK); #1;
        end
        WDATA = $urandom(); #2;
        in_rst = 1'b1; ARESETN = 1'b0; WVALID = 1'b0; #1;
        chk("mid_rst_awready", AWREADY, 0); chk("mid_rst_wready", WREADY, 0);
        chk("mid_rst_bvalid", BVALID, 0);   chk("mid_rst_bresp", BRESP, 0);
        chk("mid_rst_arready", ARREADY, 0); chk("mid_rst_rvalid", RVALID, 0);
        chk("mid_rst_rdata", RDATA, 0);     chk("mid_rst_rresp", RRESP, 0);
        for (int i = 8'hC0; i < 8'hC8; i++) mdl_ok[i] = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1; in_rst = 1'b0;
        @(negedge ACLK);
        chk("rel_awready", AWREADY, 1); chk("rel_arready", ARREADY, 1);
        do_write(32'h300, 8'd7, 3'd2, 2'b01, 32'h900, 0, 0, 0, lat);
        chk("rel_w_latency", lat, 9);
        chk("rel_bresp", last_bresp, 2'b00);
        do_read(32'h30C, 8'd0, 3'd2, 2'b01, 0, hs);
        chk_got("rel_r", 0, 32'h903, 2'b00);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a; logic [7:0] len; logic [2:0] sz; logic [1:0] bu; int sel;
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = 32'($urandom_range(0, 1023));
            else if (sel < 9) a = 32'h3C0 + 32'($urandom_range(0, 127));
            else              a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            len = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
            sz  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
            bu  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) do_write(a, len, sz, bu, 32'd0, 1, 1, $urandom_range(0, 3), lat2);
            else                           do_read(a, len, sz, bu, 1, hs2);
        end

        repeat (3) @(negedge ACLK);
        chk("end_exp_r_empty", exp_r.size(), 0);
        chk("end_exp_b_empty", exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
